// File: rtl/i2s_tdm_trx.sv
`default_nettype none
// ============================================================================
// Module   : i2s_tdm_trx
// Brief    : Multi-slot I2S/TDM master transceiver, single mclk_in domain.
//            Define I2S_TDM_TRX_LOOPBACK_EN to add the loopback_in port.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_tdm_trx #(
  parameter int CHANNELS      = 2,
  parameter int SLOT_WIDTH    = 32,
  parameter int PDATA_WIDTH   = 24,
  parameter int MCLK_DIV_SCLK = 4,
  parameter int FSYNC_MODE    = 0
) (
  input  logic                            mclk_in,
  input  logic                            arstn_in,
  output logic                            sclk_out,
  output logic                            fsync_out,
  input  logic                            sdata_in,
  output logic                            sdata_out,
  input  logic [CHANNELS*PDATA_WIDTH-1:0] tx_data_in,
  input  logic                            tx_valid_in,
  output logic                            tx_ready_out,
  output logic                            tx_underrun_out,
  output logic [CHANNELS*PDATA_WIDTH-1:0] rx_data_out,
  output logic                            rx_valid_out
`ifdef I2S_TDM_TRX_LOOPBACK_EN
  ,
  input  logic                            loopback_in
`endif
);

  localparam int c_frame = CHANNELS * SLOT_WIDTH;
  localparam int c_dw    = CHANNELS * PDATA_WIDTH;
  localparam int c_bw    = $clog2(c_frame);
  localparam int c_sw    = $clog2(SLOT_WIDTH);
  localparam int c_vw    = $clog2(MCLK_DIV_SCLK);

  localparam logic [c_vw-1:0] c_div_rise  = c_vw'(MCLK_DIV_SCLK / 2 - 1);
  localparam logic [c_vw-1:0] c_div_last  = c_vw'(MCLK_DIV_SCLK - 1);
  localparam logic [c_bw-1:0] c_bit_last  = c_bw'(c_frame - 1);
  localparam logic [c_bw-1:0] c_bit_half  = c_bw'(c_frame / 2);
  localparam logic [c_sw-1:0] c_slot_last = c_sw'(SLOT_WIDTH - 1);

  logic [c_vw-1:0]    div_cnt_q, div_cnt_d;
  logic [c_bw-1:0]    bit_cnt_q, bit_cnt_d;
  logic [c_sw-1:0]    slot_bit_q, slot_bit_d;
  logic               sclk_q, sclk_d;
  logic               fsync_q, fsync_d;
  logic               sdata_q, sdata_d;
  logic [c_frame-1:0] tx_shift_q, tx_shift_d;
  logic [c_dw-1:0]    hold_q, hold_d;
  logic               tx_ready_q, tx_ready_d;
  logic               tx_underrun_q, tx_underrun_d;
  logic [c_dw-1:0]    rx_shift_q, rx_shift_d;
  logic               rx_armed_q, rx_armed_d;
  logic [c_dw-1:0]    rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;

  logic               w_rise, w_fall, w_load, w_hs, w_rx_bit, w_rx_take;
  logic [c_bw-1:0]    w_bit_nxt;
  logic [c_sw-1:0]    w_slot_nxt;
  logic [c_frame-1:0] w_frame;
  logic [c_dw-1:0]    w_rx_next, w_rx_frame;

  // Slot k occupies the k-th SLOT_WIDTH field from the top, sample MSB-aligned.
  function automatic logic [c_frame-1:0] format_frame(input logic [c_dw-1:0] d);
    logic [c_frame-1:0] f;
    f = '0;
    for (int k = 0; k < CHANNELS; k++)
      f[c_frame-1-k*SLOT_WIDTH -: PDATA_WIDTH] = d[k*PDATA_WIDTH +: PDATA_WIDTH];
    return f;
  endfunction

  // The rx shifter holds slot 0 at the top; the port wants channel k at k*PW.
  function automatic logic [c_dw-1:0] slot_order(input logic [c_dw-1:0] s);
    logic [c_dw-1:0] r;
    r = '0;
    for (int k = 0; k < CHANNELS; k++)
      r[k*PDATA_WIDTH +: PDATA_WIDTH] = s[c_dw-1-k*PDATA_WIDTH -: PDATA_WIDTH];
    return r;
  endfunction

  always_comb begin
    w_rise     = (div_cnt_q == c_div_rise);
    w_fall     = (div_cnt_q == c_div_last);
    w_bit_nxt  = (bit_cnt_q == c_bit_last) ? '0 : bit_cnt_q + c_bw'(1);
    w_slot_nxt = (slot_bit_q == c_slot_last) ? '0 : slot_bit_q + c_sw'(1);
    w_load     = w_fall && (w_bit_nxt == c_bw'(1));
    w_hs       = tx_valid_in && tx_ready_q;
`ifdef I2S_TDM_TRX_LOOPBACK_EN
    w_rx_bit   = loopback_in ? sdata_q : sdata_in;
`else
    w_rx_bit   = sdata_in;
`endif
    // The bit on the line lags the period by one, so slot position is slot_bit-1.
    w_rx_take  = (slot_bit_q == '0) ? (PDATA_WIDTH == SLOT_WIDTH)
                                    : (int'(slot_bit_q) <= PDATA_WIDTH);
    w_rx_next  = {rx_shift_q[c_dw-2:0], w_rx_bit};
    w_rx_frame = w_rx_take ? w_rx_next : rx_shift_q;
    w_frame    = '0;

    div_cnt_d     = w_fall ? '0 : div_cnt_q + c_vw'(1);
    bit_cnt_d     = bit_cnt_q;
    slot_bit_d    = slot_bit_q;
    sclk_d        = sclk_q;
    fsync_d       = fsync_q;
    sdata_d       = sdata_q;
    tx_shift_d    = tx_shift_q;
    hold_d        = hold_q;
    tx_ready_d    = tx_ready_q;
    tx_underrun_d = 1'b0;
    rx_shift_d    = rx_shift_q;
    rx_armed_d    = rx_armed_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;

    if (w_rise) begin
      sclk_d = 1'b1;
      if (w_rx_take) rx_shift_d = w_rx_next;
      if (bit_cnt_q == '0 && rx_armed_q) begin
        rx_data_d  = slot_order(w_rx_frame);
        rx_valid_d = 1'b1;
      end
      // Stream bit 0 is sampled in period 1: only from here is a frame complete.
      if (bit_cnt_q == c_bw'(1)) rx_armed_d = 1'b1;
    end

    if (w_fall) begin
      sclk_d     = 1'b0;
      bit_cnt_d  = w_bit_nxt;
      slot_bit_d = w_slot_nxt;
      fsync_d    = (FSYNC_MODE == 0) ? (w_bit_nxt >= c_bit_half) : (w_bit_nxt == '0);
    end

    if (w_load) begin
      if (!tx_ready_q) begin
        w_frame    = format_frame(hold_q);
        tx_ready_d = 1'b1;
      end else if (w_hs) begin
        w_frame = format_frame(tx_data_in);
      end else begin
        tx_underrun_d = 1'b1;
      end
      sdata_d    = w_frame[c_frame-1];
      tx_shift_d = {w_frame[c_frame-2:0], 1'b0};
    end else begin
      if (w_fall) begin
        sdata_d    = tx_shift_q[c_frame-1];
        tx_shift_d = {tx_shift_q[c_frame-2:0], 1'b0};
      end
      if (w_hs) begin
        hold_d     = tx_data_in;
        tx_ready_d = 1'b0;
      end
    end
  end

  always_ff @(posedge mclk_in or negedge arstn_in) begin
    if (!arstn_in) begin
      div_cnt_q     <= '0;
      bit_cnt_q     <= c_bit_last;
      slot_bit_q    <= c_slot_last;
      sclk_q        <= 1'b0;
      fsync_q       <= 1'b0;
      sdata_q       <= 1'b0;
      tx_shift_q    <= '0;
      hold_q        <= '0;
      tx_ready_q    <= 1'b1;
      tx_underrun_q <= 1'b0;
      rx_shift_q    <= '0;
      rx_armed_q    <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      slot_bit_q    <= slot_bit_d;
      sclk_q        <= sclk_d;
      fsync_q       <= fsync_d;
      sdata_q       <= sdata_d;
      tx_shift_q    <= tx_shift_d;
      hold_q        <= hold_d;
      tx_ready_q    <= tx_ready_d;
      tx_underrun_q <= tx_underrun_d;
      rx_shift_q    <= rx_shift_d;
      rx_armed_q    <= rx_armed_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
    end
  end

  assign sclk_out        = sclk_q;
  assign fsync_out       = fsync_q;
  assign sdata_out       = sdata_q;
  assign tx_ready_out    = tx_ready_q;
  assign tx_underrun_out = tx_underrun_q;
  assign rx_data_out     = rx_data_q;
  assign rx_valid_out    = rx_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_tdm_trx.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_tdm_trx
// Brief    : Directed bench for i2s_tdm_trx, 4 slots x 32 sclk, 24-bit, DIV 4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_tdm_trx;

  localparam int CH = 4;
  localparam int SW = 32;
  localparam int PW = 24;
  localparam int DIV = 4;
  localparam int FR = CH * SW;
  localparam int DW = CH * PW;

  logic          mclk_in  = 1'b0;
  logic          arstn_in = 1'b0;
  logic          sdata_in = 1'b0;
  logic [DW-1:0] tx_data  = '0;
  logic          tx_valid = 1'b0;
  logic          lb_en    = 1'b0;
  logic [DW-1:0] zero_dw  = '0;
  logic          zero_b   = 1'b0;

  logic          sclk, fsync, sdata, tx_ready, tx_underrun, rx_valid;
  logic [DW-1:0] rx_data;
  logic          sclk1, fsync1, sdata1, tx_ready1, tx_underrun1, rx_valid1;
  logic [DW-1:0] rx_data1;

  i2s_tdm_trx #(.CHANNELS(CH), .SLOT_WIDTH(SW), .PDATA_WIDTH(PW),
                .MCLK_DIV_SCLK(DIV), .FSYNC_MODE(0)) dut (
    .mclk_in(mclk_in), .arstn_in(arstn_in), .sclk_out(sclk), .fsync_out(fsync),
    .sdata_in(sdata_in), .sdata_out(sdata), .tx_data_in(tx_data),
    .tx_valid_in(tx_valid), .tx_ready_out(tx_ready), .tx_underrun_out(tx_underrun),
    .rx_data_out(rx_data), .rx_valid_out(rx_valid)
`ifdef I2S_TDM_TRX_LOOPBACK_EN
    , .loopback_in(lb_en)
`endif
  );

  i2s_tdm_trx #(.CHANNELS(CH), .SLOT_WIDTH(SW), .PDATA_WIDTH(PW),
                .MCLK_DIV_SCLK(DIV), .FSYNC_MODE(1)) dut_tdm (
    .mclk_in(mclk_in), .arstn_in(arstn_in), .sclk_out(sclk1), .fsync_out(fsync1),
    .sdata_in(sdata_in), .sdata_out(sdata1), .tx_data_in(zero_dw),
    .tx_valid_in(zero_b), .tx_ready_out(tx_ready1), .tx_underrun_out(tx_underrun1),
    .rx_data_out(rx_data1), .rx_valid_out(rx_valid1)
`ifdef I2S_TDM_TRX_LOOPBACK_EN
    , .loopback_in(zero_b)
`endif
  );

  always #5 mclk_in = ~mclk_in;

  int checks   = 0;
  int failures = 0;
  int k        = -1;
  logic [FR-1:0] codec_frame = '0;

  task automatic check(input string tag, input logic [FR-1:0] act, input logic [FR-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pack(input logic [23:0] c0, c1, c2, c3);
    return {c3, c2, c1, c0};
  endfunction

  function automatic logic [FR-1:0] fmt(input logic [23:0] c0, c1, c2, c3);
    return {c0, 8'h00, c1, 8'h00, c2, 8'h00, c3, 8'h00};
  endfunction

  // k = index of the last mclk edge; the first fall is edge 3 and enters period 0.
  // The codec drives stream bit (b-1) mod FR right after each fall.
  task automatic step();
    int b, s;
    @(posedge mclk_in);
    #1;
    k++;
    if (k >= 3 && (k - 3) % DIV == 0) begin
      b = ((k - 3) / DIV) % FR;
      s = (b + FR - 1) % FR;
      sdata_in = codec_frame[FR-1-s];
    end
  endtask

  task automatic do_reset();
    @(posedge mclk_in);
    #1;
    arstn_in = 1'b0;
    #2;
    check("rst_sclk", sclk, 0);
    check("rst_fsync", fsync, 0);
    check("rst_sdata", sdata, 0);
    check("rst_ready", tx_ready, 1);
    check("rst_underrun", tx_underrun, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    @(negedge mclk_in);
    arstn_in = 1'b1;
    sdata_in = 1'b0;
    k = -1;
  endtask

  initial begin
    int fr[4], ff[4], sr[4], rv[4], ur[4];
    int nfr, nff, nsr, nrv, nur, fs1_cnt, fs1_first;
    logic prev_fs, prev_sclk, prev_fs1, rdy0, sd_or, rdy519;
    logic [FR-1:0] line0, line1, line2;
    logic [DW-1:0] rx_first, codec_exp;

    codec_frame = {24'h123456, 8'hFF, 24'h000000, 8'hFF, 24'h800001, 8'h00, 24'hABCDEF, 8'h5A};
    codec_exp   = pack(24'h123456, 24'h000000, 24'h800001, 24'hABCDEF);

    // ---- Phase 1: timing, tx with held valid, rx from codec, TDM fsync ----
    tx_valid = 1'b1;
    tx_data  = pack(24'h111111, 24'h222222, 24'h333333, 24'h444444);
    do_reset();
    nfr = 0; nff = 0; nsr = 0; nrv = 0; nur = 0; fs1_cnt = 0; fs1_first = -1;
    prev_fs = 0; prev_sclk = 0; prev_fs1 = 0; rdy0 = 0;
    line0 = '0; line1 = '0; rx_first = '0;
    while (k < 1100) begin
      step();
      if (k == 0) begin
        rdy0    = tx_ready;
        tx_data = pack(24'hA5A5A5, 24'h123456, 24'hFFFFFF, 24'h000001);
      end
      if (k == 2) begin
        check("pre_fall_fsync", fsync, 0);
        check("pre_fall_sdata", sdata, 0);
      end
      if (fsync && !prev_fs) begin if (nfr < 4) fr[nfr] = k; nfr++; end
      if (!fsync && prev_fs) begin if (nff < 4) ff[nff] = k; nff++; end
      if (sclk && !prev_sclk) begin if (nsr < 4) sr[nsr] = k; nsr++; end
      if (fsync1) begin fs1_cnt++; if (fs1_first < 0) fs1_first = k; end
      if (rx_valid) begin if (nrv < 4) rv[nrv] = k; if (nrv == 0) rx_first = rx_data; nrv++; end
      if (tx_underrun) nur++;
      if (k >= 7 && (k - 7) % DIV == 0) begin
        if ((k - 7) / DIV < FR) line0[FR-1-(k-7)/DIV] = sdata;
        else if ((k - 7) / DIV < 2 * FR) line1[FR-1-((k-7)/DIV-FR)] = sdata;
      end
      prev_fs = fsync; prev_sclk = sclk; prev_fs1 = fsync1;
    end
    check("ready_after_hs", rdy0, 0);
    check("sclk_rise_first", sr[0], 1);
    check("sclk_period", sr[1] - sr[0], DIV);
    check("fsync_rise_cnt", nfr, 2);
    check("fsync_first_rise", fr[0], 259);
    check("fsync_first_fall", ff[0], 515);
    check("fsync_period", fr[1] - fr[0], 512);
    check("fsync_high_len", ff[0] - fr[0], 256);
    check("tx_frame_a", line0, fmt(24'h111111, 24'h222222, 24'h333333, 24'h444444));
    check("tx_frame_b", line1, fmt(24'hA5A5A5, 24'h123456, 24'hFFFFFF, 24'h000001));
    check("tx_no_underrun", nur, 0);
    check("rx_strobe_cnt", nrv, 2);
    check("rx_first_strobe", rv[0], 517);
    check("rx_strobe_period", rv[1] - rv[0], 512);
    check("rx_frame", rx_first, codec_exp);
    check("rx_ch2", rx_first[2*PW +: PW], 24'h800001);
    check("tdm_fsync_first", fs1_first, 3);
    check("tdm_fsync_cycles", fs1_cnt, 12);

    // ---- Phase 2: underrun, then valid only in the load cycle (bypass) ----
    tx_valid = 1'b0;
    do_reset();
    nur = 0; sd_or = 0; rdy519 = 0; line2 = '0;
    while (k < 1040) begin
      step();
      if (tx_underrun) begin if (nur < 4) ur[nur] = k; nur++; end
      if (k >= 7 && k <= 518) sd_or = sd_or | sdata;
      if (k == 518) begin
        tx_valid = 1'b1;
        tx_data  = pack(24'hC00000, 24'h0F0F0F, 24'h7FFFFF, 24'h000100);
      end
      if (k == 519) begin tx_valid = 1'b0; rdy519 = tx_ready; end
      if (k >= 519 && (k - 519) % DIV == 0 && (k - 519) / DIV < FR)
        line2[FR-1-(k-519)/DIV] = sdata;
    end
    check("underrun_cnt", nur, 2);
    check("underrun_first", ur[0], 7);
    check("underrun_after_bypass", ur[1], 1031);
    check("underrun_zeros", sd_or, 0);
    check("bypass_ready", rdy519, 1);
    check("bypass_frame", line2, fmt(24'hC00000, 24'h0F0F0F, 24'h7FFFFF, 24'h000100));

    // ---- Phase 3: reset mid-slot (period 3), no strobe before a full frame ----
    do_reset();
    nrv = 0; rx_first = '0;
    while (k < 1040) begin
      step();
      if (rx_valid) begin if (nrv < 4) rv[nrv] = k; if (nrv == 0) rx_first = rx_data; nrv++; end
    end
    check("midrst_strobe_cnt", nrv, 2);
    check("midrst_first_strobe", rv[0], 517);
    check("midrst_rx_frame", rx_first, codec_exp);

`ifdef I2S_TDM_TRX_LOOPBACK_EN
    // ---- Phase 4: loopback, each strobe returns the frame sent before it ----
    begin
      logic [DW-1:0] lb[0:101];
      int idx, nst;
      logic hs;
      for (int i = 0; i < 102; i++)
        lb[i] = pack(24'($urandom), 24'($urandom), 24'($urandom), 24'($urandom));
      lb_en    = 1'b1;
      tx_valid = 1'b1;
      tx_data  = lb[0];
      idx = 0; nst = 0;
      do_reset();
      while (nst < 100 && k < 100 * 512 + 2000) begin
        hs = tx_valid && tx_ready;
        step();
        if (hs && idx < 101) begin idx++; tx_data = lb[idx]; end
        if (rx_valid) begin
          check("loopback_frame", rx_data, lb[nst]);
          nst++;
        end
      end
      check("loopback_strobes", nst, 100);
      tx_valid = 1'b0;
      lb_en    = 1'b0;
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
